// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: 16x-oversampling UART receiver with configurable frame format,
// parity/framing error flags and break detection.
module uart_rx_cfg #(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_rx,
  input  logic                 rst_clk_rx_n,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_rdy,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 brk_det
);
  localparam int DIVIDER = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int BW = DIVIDER > 1 ? $clog2(DIVIDER) : 1;
  localparam logic [BW-1:0] DIV_MAX = BW'(DIVIDER - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [BW-1:0] baud_q;
  logic [3:0] os_q, os_d, cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic perr_q, perr_d, ferr_q, ferr_d, done_q, done_d;
  logic rxd_s, tick, mid;
  assign rxd_s = sync_q[1];
  assign tick = baud_q == DIV_MAX;
  // os_q is zeroed at the start-bit centre, so each wrap to 15 lands on a bit centre
  assign mid = tick && os_q == 4'd15;
  assign brk_det = state_q == S_BRK;
  always_ff @(posedge clk_rx or negedge rst_clk_rx_n)
    if (!rst_clk_rx_n) begin
      sync_q      <= 2'b11;
      baud_q      <= '0;
      state_q     <= S_IDLE;
      os_q        <= '0;
      cnt_q       <= '0;
      sh_q        <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      done_q      <= 1'b0;
      rx_data     <= '0;
      rx_data_rdy <= 1'b0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd_i};
      baud_q      <= tick ? '0 : baud_q + 1'b1;
      state_q     <= state_d;
      os_q        <= os_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      done_q      <= done_d;
      rx_data_rdy <= done_q;
      if (done_q) begin
        rx_data <= sh_q;
        par_err <= perr_q;
        frm_err <= ferr_q;
      end
    end
  always_comb begin
    state_d = state_q;
    os_d    = tick ? os_q + 4'd1 : os_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:
        if (tick && !rxd_s) begin
          state_d = S_START;
          os_d    = '0;
          cnt_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      S_START:
        if (tick && os_q == 4'd7) begin
          state_d = rxd_s ? S_IDLE : S_DATA;
          os_d    = '0;
        end
      S_DATA:
        if (mid) begin
          sh_d    = {rxd_s, sh_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q == LAST_D ? '0 : cnt_q + 4'd1;
          state_d = cnt_q != LAST_D ? S_DATA : PARITY != 0 ? S_PAR : S_STOP;
        end
      S_PAR:
        if (mid) begin
          perr_d  = ^{sh_q, rxd_s} ^ (PARITY == 1);
          state_d = S_STOP;
        end
      S_STOP:
        if (mid) begin
          ferr_d = ferr_q | ~rxd_s;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == LAST_S) begin
            done_d  = 1'b1;
            state_d = ferr_d && sh_q == '0 ? S_BRK : S_IDLE;
          end
        end
      S_BRK:
        if (tick && rxd_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: drives serial frames into three receiver configurations
// (8N1 default, 8E1 fast, 7N2 fast) and checks received characters and flags.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam int CR   = 50_000_000;
  localparam int FAST = 781_250;
  localparam int BA   = 16 * (CR / (115_200 * 16));
  localparam int BF   = 16 * (CR / (FAST * 16));
  typedef struct { logic [8:0] d; logic p; logic f; int c; } rec_t;
  logic clk = 1'b0, rst_n = 1'b0, rxa = 1'b1, rxb = 1'b1, rxc = 1'b1;
  logic [7:0] da, db;
  logic [6:0] dc;
  logic [2:0] rdy, pe, fe, bk;
  int cyc = 0, bk_cnt = 0, checks = 0, errors = 0;
  rec_t qa[$], qb[$], qc[$], eb[$], ec[$];
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_rx_cfg u_a (
    .clk_rx(clk), .rst_clk_rx_n(rst_n), .rxd_i(rxa), .rx_data(da),
    .rx_data_rdy(rdy[0]), .par_err(pe[0]), .frm_err(fe[0]), .brk_det(bk[0])
  );
  uart_rx_cfg #(.BAUD_RATE(FAST), .PARITY(2)) u_b (
    .clk_rx(clk), .rst_clk_rx_n(rst_n), .rxd_i(rxb), .rx_data(db),
    .rx_data_rdy(rdy[1]), .par_err(pe[1]), .frm_err(fe[1]), .brk_det(bk[1])
  );
  uart_rx_cfg #(.BAUD_RATE(FAST), .DATA_BITS(7), .STOP_BITS(2)) u_c (
    .clk_rx(clk), .rst_clk_rx_n(rst_n), .rxd_i(rxc), .rx_data(dc),
    .rx_data_rdy(rdy[2]), .par_err(pe[2]), .frm_err(fe[2]), .brk_det(bk[2])
  );
  always @(negedge clk) begin
    if (rdy[0]) qa.push_back('{9'(da), pe[0], fe[0], cyc});
    if (rdy[1]) qb.push_back('{9'(db), pe[1], fe[1], cyc});
    if (rdy[2]) qc.push_back('{9'(dc), pe[2], fe[2], cyc});
    if (bk[0]) bk_cnt <= bk_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int ch, input logic v, input int n);
    if (ch == 0) rxa = v;
    else if (ch == 1) rxb = v;
    else rxc = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  // start, LSB-first data, optional parity (flip corrupts it), stop bits (sm bit set = forced 0)
  task automatic send(input int ch, input logic [8:0] d, input int nd, input int pm,
                      input int ns, input logic flip, input logic [1:0] sm, input int bt);
    logic p;
    p = flip ^ (pm == 1);
    drive(ch, 1'b0, bt);
    for (int i = 0; i < nd; i++) begin
      p ^= d[i];
      drive(ch, d[i], bt);
    end
    if (pm != 0) drive(ch, p, bt);
    for (int i = 0; i < ns; i++) drive(ch, ~sm[i], bt);
  endtask
  task automatic expect_a(input string tag, input logic [8:0] d, input logic p, input logic f,
                          output int c);
    rec_t r;
    c = 0;
    chk({tag, "_cnt"}, qa.size(), 1);
    if (qa.size() != 0) begin
      r = qa.pop_front();
      c = r.c;
      chk({tag, "_d"}, r.d, d);
      chk({tag, "_p"}, {31'b0, r.p}, {31'b0, p});
      chk({tag, "_f"}, {31'b0, r.f}, {31'b0, f});
    end
    qa.delete();
  endtask
  initial begin
    #1_800_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, c, n, b0;
    string s;
    s = "Welcome to Our training";
    repeat (3) @(posedge clk);
    #1;
    chk("rst_da", da, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_pe", pe, 0);
    chk("rst_fe", fe, 0);
    chk("rst_bk", bk, 0);
    rst_n = 1'b1;
    drive(0, 1'b1, BA);
    t0 = cyc;
    send(0, 9'h57, 8, 0, 1, 1'b0, 2'b00, BA);
    drive(0, 1'b1, BA);
    expect_a("w", 9'h57, 1'b0, 1'b0, c);
    chk("w_lat", {31'b0, (c - t0) * 10 >= 93 * BA && (c - t0) * 10 <= 98 * BA}, 1);
    b0 = bk_cnt;
    send(0, 9'hA5, 8, 0, 1, 1'b0, 2'b01, BA);
    drive(0, 1'b1, 2 * BA);
    expect_a("fe", 9'hA5, 1'b0, 1'b1, c);
    chk("fe_brk", bk_cnt - b0, 0);
    drive(0, 1'b0, 12 * BA);
    expect_a("brk", 9'h00, 1'b0, 1'b1, c);
    chk("brk_hi", {31'b0, bk[0]}, 1);
    rxa = 1'b1;
    n = 0;
    while (bk[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("brk_clr_t", {31'b0, n <= 30}, 1);
    chk("brk_clr", {31'b0, bk[0]}, 0);
    drive(0, 1'b1, 2 * BA);
    chk("brk_extra", qa.size(), 0);
    drive(0, 1'b0, 4 * (BA / 16));
    drive(0, 1'b1, 2 * BA);
    chk("gl_rdy", qa.size(), 0);
    chk("gl_hold_d", da, 0);
    chk("gl_hold_f", {31'b0, fe[0]}, 1);
    send(0, 9'h6F, 8, 0, 1, 1'b0, 2'b00, BA);
    drive(0, 1'b1, BA);
    expect_a("6f", 9'h6F, 1'b0, 1'b0, c);
    drive(0, 1'b0, BA);
    drive(0, 1'b1, BA);
    drive(0, 1'b1, BA);
    drive(0, 1'b0, BA);
    drive(0, 1'b0, BA / 2);
    rst_n = 1'b0;
    #2;
    chk("mr_da", da, 0);
    chk("mr_rdy", {31'b0, rdy[0]}, 0);
    chk("mr_pe", {31'b0, pe[0]}, 0);
    chk("mr_fe", {31'b0, fe[0]}, 0);
    chk("mr_bk", {31'b0, bk[0]}, 0);
    drive(0, 1'b0, BA / 2);
    drive(0, 1'b1, BA);
    drive(0, 1'b1, BA);
    drive(0, 1'b0, BA);
    drive(0, 1'b0, BA);
    drive(0, 1'b1, BA);
    rst_n = 1'b1;
    drive(0, 1'b1, 2 * BA);
    chk("mr_none", qa.size(), 0);
    fork
      begin
        eb.push_back('{9'h41, 1'b1, 1'b0, 0});
        send(1, 9'h41, 8, 2, 1, 1'b1, 2'b00, BF);
        drive(1, 1'b1, 2 * BF);
        eb.push_back('{9'h41, 1'b0, 1'b0, 0});
        send(1, 9'h41, 8, 2, 1, 1'b0, 2'b00, BF);
        drive(1, 1'b1, 2 * BF);
        for (int i = 0; i < 12; i++) begin
          logic [8:0] d;
          logic fl, st;
          d  = 9'($urandom_range(0, 255));
          fl = 1'($urandom_range(0, 1));
          st = $urandom_range(0, 3) == 0;
          eb.push_back('{d, fl, st, 0});
          send(1, d, 8, 2, 1, fl, {1'b0, st}, BF);
          drive(1, 1'b1, 2 * BF);
        end
      end
      begin
        for (int i = 0; i < s.len(); i++) begin
          ec.push_back('{9'(s[i]), 1'b0, 1'b0, 0});
          send(2, 9'(s[i]), 7, 0, 2, 1'b0, 2'b00, BF);
        end
        drive(2, 1'b1, 2 * BF);
        for (int i = 0; i < 10; i++) begin
          logic [8:0] d;
          logic [1:0] sm;
          d  = 9'($urandom_range(0, 127));
          sm = 2'($urandom_range(0, 3));
          ec.push_back('{d, 1'b0, |sm, 0});
          send(2, d, 7, 0, 2, 1'b0, sm, BF);
          drive(2, 1'b1, 2 * BF);
        end
      end
    join
    drive(0, 1'b1, BF);
    chk("b_cnt", qb.size(), eb.size());
    foreach (eb[i])
      if (i < qb.size()) begin
        chk($sformatf("b%0d_d", i), qb[i].d, eb[i].d);
        chk($sformatf("b%0d_p", i), {31'b0, qb[i].p}, {31'b0, eb[i].p});
        chk($sformatf("b%0d_f", i), {31'b0, qb[i].f}, {31'b0, eb[i].f});
      end
    chk("c_cnt", qc.size(), ec.size());
    foreach (ec[i])
      if (i < qc.size()) begin
        chk($sformatf("c%0d_d", i), qc[i].d, ec[i].d);
        chk($sformatf("c%0d_p", i), {31'b0, qc[i].p}, {31'b0, ec[i].p});
        chk($sformatf("c%0d_f", i), {31'b0, qc[i].f}, {31'b0, ec[i].f});
      end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- CLOCK_RATE, 50_000_000: clk_rx frequency in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- DATA_BITS, 8: data bits per frame; legal range 5 to 9.
- PARITY, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: expected stop bits; legal values 1 or 2.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_rx, in, 1: the single clock.
- rst_clk_rx_n, in, 1: reset; asynchronous, active-low.
- rxd_i, in, 1: asynchronous serial line; idle level high.
- rx_data, out, DATA_BITS: last received character.
- rx_data_rdy, out, 1: one-cycle strobe marking a completed frame.
- par_err, out, 1: parity error for the frame flagged by rx_data_rdy.
- frm_err, out, 1: framing error for the frame flagged by rx_data_rdy.
- brk_det, out, 1: level; high while a break condition persists.

Function
REQ-003 rxd_i SHALL pass through a 2-flop synchronizer, reset to 1, before any use.
- All sampling in REQ-005 to REQ-010 SHALL use the synchronized value.

REQ-004 The baud generator SHALL provide the 16x oversample tick.
- DIVIDER = floor(CLOCK_RATE / (BAUD_RATE*16)), which is 27 at the defaults.
- A counter SHALL count 0 to DIVIDER-1 and wrap to 0, pulsing the tick for one clk_rx cycle on each wrap.
- The counter SHALL run freely and is never resynchronized to the line.

REQ-005 The receiver state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK.
- The machine SHALL leave reset in IDLE.

REQ-006 IDLE: on the first tick that sees the line low, the machine SHALL go to START with the oversample counter cleared to 0.

REQ-007 START: on oversample count 7 (mid-bit), the machine SHALL sample the line.
- If the sample is high, the event is a false start and the machine SHALL return to IDLE with no outputs.
- If the sample is low, the machine SHALL go to DATA.

REQ-008 DATA: the machine SHALL sample at every 16th tick (the mid-bit point), receiving DATA_BITS bits, LSB first, into a shift register.
- After the last bit, the machine SHALL go to PARITY if PARITY != 0, otherwise to STOP.

REQ-009 PARITY: the machine SHALL sample one bit at mid-bit.
- The parity error SHALL be set when XOR(data, parity bit) = 0 in odd mode, or = 1 in even mode.

REQ-010 STOP: the machine SHALL sample STOP_BITS bits at mid-bit.
- Any stop sample of 0 SHALL set the framing error.

REQ-011 Frame completion SHALL occur at the clock after the mid-sample of the last stop bit. At that clock:
- rx_data SHALL load the shift register.
- par_err and frm_err SHALL be updated.
- rx_data_rdy SHALL be high for exactly one clk_rx cycle.

REQ-012 rx_data, par_err and frm_err SHALL hold their values until the next frame completion.
- This holds even across false starts.

REQ-013 If the frame has a framing error and all data bits were 0, the machine SHALL enter BREAK instead of IDLE.
- brk_det SHALL be high in BREAK.
- The machine SHALL return to IDLE on the first tick sampling the line high; brk_det SHALL clear in the same clock.

REQ-014 Otherwise, frame completion SHALL return the machine to IDLE.
- A new start edge SHALL be accepted from the next tick, so back-to-back frames with no idle gap are received.

REQ-015 A frame in progress SHALL be unaffected by line activity except at sample points.
- There is no early abort on a mid-frame glitch.

Reset
REQ-016 While rst_clk_rx_n = 0 (asynchronous assertion), outputs and internal registers SHALL take these values:
- rx_data = 0, rx_data_rdy = 0, par_err = 0, frm_err = 0, brk_det = 0.
- State = IDLE, baud and oversample counters = 0, synchronizer = 1.

REQ-017 Reset asserted mid-frame SHALL discard the partial frame with no rx_data_rdy pulse.
- Deassertion SHALL be synchronized by the existing reset bridge outside this block.
- The first clk_rx edge after deassertion SHALL start normal operation.

Verification
REQ-018 The bench SHALL cover these directed scenarios (defaults unless stated):
- 8N1, send 0x57 ('W'): exactly one rx_data_rdy pulse; rx_data = 0x57; par_err = 0; frm_err = 0; pulse about 9.5 bit times after the start edge.
- PARITY = 2, send 0x41 with parity bit forced to 1: rx_data = 0x41, par_err = 1. Then send 0x41 with correct parity bit 0: par_err = 0.
- Send 0xA5 with stop bit forced to 0, then line held high: frm_err = 1, rx_data = 0xA5, brk_det stays 0.
- Line low for 12 bit times: one pulse with rx_data = 0x00, frm_err = 1; brk_det = 1 until the line rises, then 0 within one tick.
- Line glitch low for 4 oversample ticks: no rx_data_rdy; following frame 0x6F received correctly.
- Reset asserted at data bit 3 of 0x33: no pulse and all outputs 0. Then DATA_BITS = 7, STOP_BITS = 2 run: the 23-character string "Welcome to Our training" sent back-to-back with no gaps, all 23 received in order with zero errors.
